bridge_scheduler: RTL

Sequences the drawbridge between road and river traffic. Counts boats waiting on each side and holds the road open for a minimum time. Clears the road, commands raise and lower through the motor, and grants boat passage to one side at a time using round-robin. Sits above the drawbridge motor/alarm FSM and drives its traffic-light and motor requests.

---
 rtl/bridge_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bridge_scheduler.sv
// rtl/bridge_scheduler.sv - drawbridge road/river sequencer with round-robin boat grants
// Define SCHED_EMERGENCY_EN to add the EmergencyReq road-priority input.
module bridge_scheduler #(
    parameter int MIN_ROAD_CYCLES = 8,
    parameter int CLEAR_TIMEOUT   = 16,
    parameter int MOVE_TIMEOUT    = 32,
    parameter int MAX_BOATS       = 4,
    parameter int CNT_W           = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BoatArrUp,
    input  logic             BoatArrDown,
    input  logic             BoatPassed,
    input  logic             CarsClear,
    input  logic             BridgeUp,
    input  logic             BridgeDown,
`ifdef SCHED_EMERGENCY_EN
    input  logic             EmergencyReq,
`endif
    output logic             RaiseCmd,
    output logic             LowerCmd,
    output logic             RoadStop,
    output logic             GoUp,
    output logic             GoDown,
    output logic             Alarm,
    output logic             Fault,
    output logic [CNT_W-1:0] QueueUp,
    output logic [CNT_W-1:0] QueueDown
);

    localparam int TMAX = (CLEAR_TIMEOUT > MOVE_TIMEOUT) ? CLEAR_TIMEOUT : MOVE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MIN_ROAD_CYCLES + 1);
    localparam int SW   = $clog2(MAX_BOATS + 1);

    localparam logic [TW-1:0]    T_ONE      = TW'(1);
    localparam logic [TW-1:0]    T_SAT      = TW'(TMAX);
    localparam logic [TW-1:0]    T_CLEAR    = TW'(CLEAR_TIMEOUT);
    localparam logic [TW-1:0]    T_MOVE     = TW'(MOVE_TIMEOUT);
    localparam logic [RW-1:0]    R_MIN      = RW'(MIN_ROAD_CYCLES);
    localparam logic [SW-1:0]    SERVED_MAX = SW'(MAX_BOATS);
    localparam logic [CNT_W-1:0] Q_MAX      = '1;

    typedef enum logic [2:0] {
        ROAD_OPEN, CLEARING, RAISING, BOAT_PASS, LOWERING, FAULT
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n, timer_inc;
    logic [RW-1:0]    road_timer, road_timer_n;
    logic [SW-1:0]    served, served_n;
    logic             last_up, last_up_n;
    logic             go_up_n, go_down_n;
    logic             pass_up, pass_down;
    logic [CNT_W-1:0] q_up_n, q_down_n;
    logic             emerg;

`ifdef SCHED_EMERGENCY_EN
    assign emerg = EmergencyReq;
`else
    assign emerg = 1'b0;
`endif

    // timer holds the number of cycles spent in the current state, counting the current one
    always_comb begin
        state_n      = state;
        timer_inc    = (timer == T_SAT) ? timer : timer + 1'b1;
        timer_n      = timer;
        road_timer_n = road_timer;
        served_n     = served;
        last_up_n    = last_up;
        go_up_n      = GoUp;
        go_down_n    = GoDown;
        case (state)
            ROAD_OPEN: begin
                if (road_timer != R_MIN) road_timer_n = road_timer + 1'b1;
                if (road_timer == R_MIN && (QueueUp != '0 || QueueDown != '0) && !emerg) begin
                    state_n = CLEARING;
                    timer_n = T_ONE;
                end
            end
            CLEARING: begin
                timer_n = timer_inc;
                if (emerg) begin
                    state_n = ROAD_OPEN;
                end else if (CarsClear) begin
                    state_n  = RAISING;
                    timer_n  = T_ONE;
                    served_n = '0;
                end
            end
            RAISING: begin
                timer_n = timer_inc;
                if (BridgeUp)              state_n = BOAT_PASS;
                else if (timer >= T_MOVE)  state_n = FAULT;
            end
            BOAT_PASS: begin
                if (GoUp || GoDown) begin
                    if (BoatPassed) begin
                        served_n  = served + 1'b1;
                        last_up_n = GoUp;
                        go_up_n   = 1'b0;
                        go_down_n = 1'b0;
                    end
                end else if ((QueueUp == '0 && QueueDown == '0) || served == SERVED_MAX || emerg) begin
                    state_n = LOWERING;
                    timer_n = T_ONE;
                end else if (QueueUp != '0 && (QueueDown == '0 || !last_up)) begin
                    go_up_n = 1'b1;
                end else begin
                    go_down_n = 1'b1;
                end
            end
            LOWERING: begin
                timer_n = timer_inc;
                if (BridgeDown) begin
                    state_n      = ROAD_OPEN;
                    road_timer_n = '0;
                end else if (timer >= T_MOVE) begin
                    state_n = FAULT;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = FAULT;
        endcase
        if (BridgeUp && BridgeDown) state_n = FAULT;
        if (state_n != BOAT_PASS) begin
            go_up_n   = 1'b0;
            go_down_n = 1'b0;
        end
    end

    // an arrival and a pass on the same side cancel out
    always_comb begin
        pass_up   = (state == BOAT_PASS) && GoUp && BoatPassed;
        pass_down = (state == BOAT_PASS) && GoDown && BoatPassed;
        q_up_n    = QueueUp;
        q_down_n  = QueueDown;
        if (BoatArrUp && !pass_up && QueueUp != Q_MAX)          q_up_n = QueueUp + 1'b1;
        else if (pass_up && !BoatArrUp && QueueUp != '0)        q_up_n = QueueUp - 1'b1;
        if (BoatArrDown && !pass_down && QueueDown != Q_MAX)    q_down_n = QueueDown + 1'b1;
        else if (pass_down && !BoatArrDown && QueueDown != '0)  q_down_n = QueueDown - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ROAD_OPEN;
            timer      <= '0;
            road_timer <= '0;
            served     <= '0;
            last_up    <= 1'b0;
            QueueUp    <= '0;
            QueueDown  <= '0;
            RaiseCmd   <= 1'b0;
            LowerCmd   <= 1'b0;
            RoadStop   <= 1'b0;
            GoUp       <= 1'b0;
            GoDown     <= 1'b0;
            Alarm      <= 1'b0;
            Fault      <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            road_timer <= road_timer_n;
            served     <= served_n;
            last_up    <= last_up_n;
            QueueUp    <= q_up_n;
            QueueDown  <= q_down_n;
            RaiseCmd   <= (state_n == RAISING);
            LowerCmd   <= (state_n == LOWERING);
            RoadStop   <= (state_n != ROAD_OPEN);
            GoUp       <= go_up_n;
            GoDown     <= go_down_n;
            Alarm      <= (state_n == FAULT) || (state_n == CLEARING && timer_n >= T_CLEAR);
            Fault      <= (state_n == FAULT);
        end
    end

endmodule
